instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  CPU clock; all state changes on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high core reset.
REQ-003 SHALL have ports: run  in  1  level; continuous execution enable.
REQ-004 SHALL have ports: step  in  1  single-cycle pulse; execute exactly one instruction while run=0.
REQ-005 SHALL have ports: fetch_ack  in  1  instruction memory has valid data for the current fetch.
REQ-006 SHALL have ports: stall  in  1  holds EXECUTE for multi-cycle operations.
REQ-007 SHALL have ports: current_state  out  3  state code driven to the control decoder.
REQ-008 SHALL have ports: fetch_req  out  1  instruction fetch request.
REQ-009 SHALL have ports: instr_done  out  1  one-cycle retire pulse.
REQ-010 SHALL have ports: busy  out  1  high in any state other than RESET_STATE.
REQ-011 SHALL have ports: fetch_err  out  1  sticky fetch-timeout flag.
REQ-012 SHALL have ports: retired_cnt  out  16  count of retired instructions.

Function
REQ-013 State codes SHALL be: RESET_STATE=000, FETCH_INSTR=001, READ_OPS=010, EXECUTE=011, WRITEBACK=100.
REQ-014 current_state SHALL be a register output, with no combinational path from any input.
REQ-015 RESET_STATE -> FETCH_INSTR when (run or step) and fetch_err=0; otherwise RESET_STATE is held.
REQ-016 FETCH_INSTR: fetch_req=1 combinationally; -> READ_OPS on the edge where fetch_ack=1.
REQ-017 Fetch wait counter: 4-bit; cleared on FETCH_INSTR entry; increments each FETCH_INSTR cycle without fetch_ack.
REQ-018 Fetch timeout: when the wait counter=15 and fetch_ack=0, fetch_err SHALL be set and the FSM SHALL go to RESET_STATE; the instruction is not retired.
REQ-019 When fetch_ack=1 coincides with timeout, ack SHALL win: READ_OPS is entered, no error.
REQ-020 READ_OPS -> EXECUTE unconditionally (one cycle).
REQ-021 EXECUTE SHALL be held while stall=1; -> WRITEBACK on the first cycle with stall=0. stall SHALL be ignored in all other states.
REQ-022 WRITEBACK SHALL be one cycle; -> FETCH_INSTR if run=1 and fetch_err=0, else RESET_STATE.
REQ-023 instr_done SHALL be high exactly during the WRITEBACK cycle.
REQ-024 step latching: a step pulse is accepted only in RESET_STATE; the step run then ends in RESET_STATE after WRITEBACK unless run=1 by then.
REQ-025 Deasserting run mid-instruction SHALL NOT abort it; the FSM SHALL complete WRITEBACK, then enter RESET_STATE.
REQ-026 Illegal codes 101-111 SHALL go to RESET_STATE on the next edge, with no instr_done.
REQ-027 retired_cnt SHALL increment on each WRITEBACK cycle, wrapping 0xFFFF -> 0x0000.

Reset
REQ-028 reset=1 SHALL take precedence over all inputs and force, on the next edge: current_state=000, wait counter=0, fetch_err=0, retired_cnt=0.
REQ-029 With current_state=000 after reset: fetch_req=0, instr_done=0, busy=0.
REQ-030 reset asserted mid-instruction SHALL abandon the instruction with no instr_done pulse.

Configuration
REQ-031 Macro SEQ_PERF_CNT_EN: when defined, retired_cnt SHALL be implemented as REQ-027.
REQ-032 When SEQ_PERF_CNT_EN is undefined, the retired_cnt port SHALL remain and be driven constant 0, with no counter flops.

Structure
REQ-033 A shared package SHALL hold the 3-bit state codes, the timeout limit (15) and the counter width (16); the control decoder SHALL use the same package.
REQ-034 One sub-module, seq_fetch_timer (wait counter plus timeout compare), SHALL be instantiated; the FSM and retire counter SHALL stay in instr_sequencer.

Verification
REQ-035 Scenario 1: reset, then run=1 with fetch_ack tied 1 -> state sequence 000,001,010,011,100,001,...; instr_done every 4th cycle; retired_cnt=3 after 3 WRITEBACKs.
REQ-036 Scenario 2: fetch_ack asserted on the 4th FETCH cycle -> FETCH held 4 cycles with fetch_req=1 throughout, then 010.
REQ-037 Scenario 3: fetch_ack=0 for 16 FETCH cycles -> fetch_err=1, state 000, held despite run=1 until reset.
REQ-038 Scenario 4: stall=1 for 2 cycles entering EXECUTE -> EXECUTE lasts 3 cycles, then 100.
REQ-039 Scenario 5: run=0 and a step pulse in 000 -> exactly one 001..100 pass, one instr_done, return to 000.
REQ-040 Scenario 6: reset asserted during EXECUTE -> 000 next cycle, no instr_done, retired_cnt=0; retired_cnt at 0xFFFF plus one retire -> 0x0000 (macro defined).

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer and the control decoder:
// 3-bit state codes, fetch timeout limit and retire counter width.
package instr_sequencer_pkg;

  typedef logic [2:0] state_t;

  localparam state_t RESET_STATE = 3'b000;
  localparam state_t FETCH_INSTR = 3'b001;
  localparam state_t READ_OPS    = 3'b010;
  localparam state_t EXECUTE     = 3'b011;
  localparam state_t WRITEBACK   = 3'b100;

  localparam int              WAIT_W        = 4;
  localparam logic [WAIT_W-1:0] FETCH_TIMEOUT = 4'd15;

  localparam int RETIRE_CNT_W = 16;

endpackage

// File: rtl/instr_sequencer_fetch_timer.sv
// Fetch wait counter and timeout compare for the instruction sequencer.
// The counter sits at zero outside FETCH_INSTR, so every fetch starts from zero.
module seq_fetch_timer
  import instr_sequencer_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic in_fetch,
  input  logic fetch_ack,
  output logic timeout
);

  logic [WAIT_W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!in_fetch) begin
      wait_cnt <= '0;
    end else if (!fetch_ack) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // An ack in the last allowed cycle still counts as a successful fetch.
  assign timeout = in_fetch && !fetch_ack && (wait_cnt == FETCH_TIMEOUT);

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer FSM: fetch / read operands / execute / writeback,
// with run and single-step control, fetch timeout and an optional retire
// counter enabled by the SEQ_PERF_CNT_EN macro (otherwise retired_cnt is 0).
module instr_sequencer
  import instr_sequencer_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic                    step,
  input  logic                    fetch_ack,
  input  logic                    stall,
  output logic [2:0]              current_state,
  output logic                    fetch_req,
  output logic                    instr_done,
  output logic                    busy,
  output logic                    fetch_err,
  output logic [RETIRE_CNT_W-1:0] retired_cnt
);

  state_t state_q;
  state_t state_d;
  logic   fetch_err_q;
  logic   fetch_timeout;

  seq_fetch_timer u_fetch_timer (
    .clk       (clk),
    .reset     (reset),
    .in_fetch  (state_q == FETCH_INSTR),
    .fetch_ack (fetch_ack),
    .timeout   (fetch_timeout)
  );

  always_comb begin
    state_d = RESET_STATE;
    case (state_q)
      RESET_STATE: state_d = ((run || step) && !fetch_err_q) ? FETCH_INSTR : RESET_STATE;
      FETCH_INSTR: begin
        if (fetch_ack)          state_d = READ_OPS;
        else if (fetch_timeout) state_d = RESET_STATE;
        else                    state_d = FETCH_INSTR;
      end
      READ_OPS:    state_d = EXECUTE;
      EXECUTE:     state_d = stall ? EXECUTE : WRITEBACK;
      // A step run (run=0) drops back to idle once its single instruction retires.
      WRITEBACK:   state_d = (run && !fetch_err_q) ? FETCH_INSTR : RESET_STATE;
      default:     state_d = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RESET_STATE;
      fetch_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fetch_timeout) begin
        fetch_err_q <= 1'b1;
      end
    end
  end

  assign current_state = state_q;
  assign fetch_req     = (state_q == FETCH_INSTR);
  assign instr_done    = (state_q == WRITEBACK);
  assign busy          = (state_q != RESET_STATE);
  assign fetch_err     = fetch_err_q;

`ifdef SEQ_PERF_CNT_EN
  logic [RETIRE_CNT_W-1:0] retired_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
    end else if (state_q == WRITEBACK) begin
      retired_q <= retired_q + RETIRE_CNT_W'(1);
    end
  end

  assign retired_cnt = retired_q;
`else
  assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: each scenario queues the expected
// per-cycle outputs, then drives inputs and compares after every clock edge.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, step, fetch_ack, stall;
  logic [2:0]  current_state;
  logic        fetch_req, instr_done, busy, fetch_err;
  logic [15:0] retired_cnt;

  instr_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .step          (step),
    .fetch_ack     (fetch_ack),
    .stall         (stall),
    .current_state (current_state),
    .fetch_req     (fetch_req),
    .instr_done    (instr_done),
    .busy          (busy),
    .fetch_err     (fetch_err),
    .retired_cnt   (retired_cnt)
  );

  always #5 clk = ~clk;

`ifdef SEQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]  st;
    logic        req;
    logic        done;
    logic        busy;
    logic        err;
    logic [15:0] cnt;
  } obs_t;

  obs_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_cnt  = 0;

  function automatic obs_t mk(input logic [2:0] st, input logic err, input int cnt);
    obs_t o;
    o.st   = st;
    o.req  = (st == 3'd1);
    o.done = (st == 3'd4);
    o.busy = (st != 3'd0);
    o.err  = err;
    o.cnt  = PERF ? 16'(cnt) : 16'd0;
    return o;
  endfunction

  // Retire count advances after every expected WRITEBACK cycle.
  task automatic push_exp(input logic [2:0] st, input logic err);
    sb.push_back(mk(st, err, exp_cnt));
    if (st == 3'd4) exp_cnt++;
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.st   = current_state;
    o.req  = fetch_req;
    o.done = instr_done;
    o.busy = busy;
    o.err  = fetch_err;
    o.cnt  = retired_cnt;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("st=%0d req=%0b done=%0b busy=%0b err=%0b cnt=%0d",
                     o.st, o.req, o.done, o.busy, o.err, o.cnt);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; step = 1'b0; fetch_ack = 1'b0; stall = 1'b0;
    tick();
    reset   = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    obs_t e, g;
    reset = 1'b1; run = 1'b1; step = 1'b1; fetch_ack = 1'b1; stall = 1'b1;
    tick();
    tick();
    exp_cnt = 0;
    push_exp(3'd0, 1'b0);
    push_exp(3'd0, 1'b0);
    e = sb.pop_front(); g = sample(); n_checks++;
    if (g !== e) $display("FAIL reset_state got %s expected %s", fmt(g), fmt(e));
    else n_pass++;
    reset = 1'b0; run = 1'b0; step = 1'b0; fetch_ack = 1'b0; stall = 1'b0;
    tick();
    e = sb.pop_front(); g = sample(); n_checks++;
    if (g !== e) $display("FAIL reset_idle got %s expected %s", fmt(g), fmt(e));
    else n_pass++;
  endtask

  task automatic test_run_continuous();
    obs_t e, g;
    do_reset();
    for (int i = 0; i < 13; i++) push_exp(3'((i % 4) + 1), 1'b0);
    for (int i = 0; i < 13; i++) begin
      run = 1'b1; fetch_ack = 1'b1;
      tick();
      e = sb.pop_front(); g = sample(); n_checks++;
      if (g !== e) $display("FAIL run_seq[%0d] got %s expected %s", i, fmt(g), fmt(e));
      else n_pass++;
    end
    n_checks++;
    if (retired_cnt !== (PERF ? 16'd3 : 16'd0))
      $display("FAIL run_retired got %0d expected %0d", retired_cnt, PERF ? 3 : 0);
    else n_pass++;
  endtask

  task automatic test_fetch_wait();
    obs_t e, g;
    logic [2:0] tbl [8];
    tbl = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    do_reset();
    for (int i = 0; i < 8; i++) push_exp(tbl[i], 1'b0);
    for (int i = 0; i < 8; i++) begin
      run = (i < 4); fetch_ack = (i >= 4);
      tick();
      e = sb.pop_front(); g = sample(); n_checks++;
      if (g !== e) $display("FAIL fetch_wait[%0d] got %s expected %s", i, fmt(g), fmt(e));
      else n_pass++;
    end
  endtask

  task automatic test_fetch_timeout();
    obs_t e, g;
    do_reset();
    for (int i = 0; i <= 20; i++) push_exp((i <= 15) ? 3'd1 : 3'd0, (i >= 16));
    for (int i = 0; i <= 20; i++) begin
      run = 1'b1; fetch_ack = 1'b0; step = (i == 18);
      tick();
      e = sb.pop_front(); g = sample(); n_checks++;
      if (g !== e) $display("FAIL timeout[%0d] got %s expected %s", i, fmt(g), fmt(e));
      else n_pass++;
    end
    step = 1'b0; reset = 1'b1;
    exp_cnt = 0;
    push_exp(3'd0, 1'b0);
    tick();
    e = sb.pop_front(); g = sample(); n_checks++;
    if (g !== e) $display("FAIL timeout_clear got %s expected %s", fmt(g), fmt(e));
    else n_pass++;
    reset = 1'b0; fetch_ack = 1'b1;
    push_exp(3'd1, 1'b0);
    tick();
    e = sb.pop_front(); g = sample(); n_checks++;
    if (g !== e) $display("FAIL timeout_restart got %s expected %s", fmt(g), fmt(e));
    else n_pass++;
  endtask

  task automatic test_ack_at_timeout();
    obs_t e, g;
    do_reset();
    for (int i = 0; i <= 15; i++) push_exp(3'd1, 1'b0);
    push_exp(3'd2, 1'b0);
    push_exp(3'd3, 1'b0);
    push_exp(3'd4, 1'b0);
    push_exp(3'd0, 1'b0);
    for (int i = 0; i <= 19; i++) begin
      run = (i < 16); fetch_ack = (i == 16);
      tick();
      e = sb.pop_front(); g = sample(); n_checks++;
      if (g !== e) $display("FAIL ack_wins[%0d] got %s expected %s", i, fmt(g), fmt(e));
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    obs_t e, g;
    logic [2:0] tbl [7];
    tbl = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
    do_reset();
    for (int i = 0; i < 7; i++) push_exp(tbl[i], 1'b0);
    for (int i = 0; i < 7; i++) begin
      run = (i < 5); fetch_ack = 1'b1; stall = (i <= 4);
      tick();
      e = sb.pop_front(); g = sample(); n_checks++;
      if (g !== e) $display("FAIL stall[%0d] got %s expected %s", i, fmt(g), fmt(e));
      else n_pass++;
    end
    stall = 1'b0;
  endtask

  task automatic test_step();
    obs_t e, g;
    logic [2:0] tbl [7];
    tbl = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd0, 3'd0};
    do_reset();
    for (int i = 0; i < 7; i++) push_exp(tbl[i], 1'b0);
    for (int i = 0; i < 7; i++) begin
      run = 1'b0; fetch_ack = 1'b1; step = (i == 0) || (i == 3);
      tick();
      e = sb.pop_front(); g = sample(); n_checks++;
      if (g !== e) $display("FAIL step[%0d] got %s expected %s", i, fmt(g), fmt(e));
      else n_pass++;
    end
    step = 1'b0;
  endtask

  task automatic test_reset_mid_instr();
    obs_t e, g;
    logic [2:0] tbl [7];
    tbl = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd2, 3'd3};
    do_reset();
    for (int i = 0; i < 7; i++) push_exp(tbl[i], 1'b0);
    for (int i = 0; i < 7; i++) begin
      run = 1'b1; fetch_ack = 1'b1;
      tick();
      e = sb.pop_front(); g = sample(); n_checks++;
      if (g !== e) $display("FAIL pre_reset[%0d] got %s expected %s", i, fmt(g), fmt(e));
      else n_pass++;
    end
    reset = 1'b1;
    exp_cnt = 0;
    push_exp(3'd0, 1'b0);
    push_exp(3'd0, 1'b0);
    tick();
    e = sb.pop_front(); g = sample(); n_checks++;
    if (g !== e) $display("FAIL reset_in_exec got %s expected %s", fmt(g), fmt(e));
    else n_pass++;
    reset = 1'b0; run = 1'b0;
    tick();
    e = sb.pop_front(); g = sample(); n_checks++;
    if (g !== e) $display("FAIL after_reset got %s expected %s", fmt(g), fmt(e));
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_run_continuous();
    test_fetch_wait();
    test_fetch_timeout();
    test_ack_at_timeout();
    test_stall();
    test_step();
    test_reset_mid_instr();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
